// File: rtl/alu_mdu_seq.sv
// ============================================================================
// alu_mdu_seq : integer ALU plus iterative multiply/divide (divider built only
//               when ALU_MDU_DIV_EN is defined)          Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module alu_mdu_seq #(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      op_sel,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t          r_state,  w_state_nxt;
  logic [XLEN-1:0] r_result, w_result_nxt;
  logic [XLEN-1:0] r_hi,     w_hi_nxt;
  logic [XLEN-1:0] r_lo,     w_lo_nxt;
  logic [XLEN-1:0] r_opnd,   w_opnd_nxt;
  logic [SHW-1:0]  r_cnt,    w_cnt_nxt;
  logic [1:0]      r_fn,     w_fn_nxt;
  logic            r_negq,   w_negq_nxt;

  function automatic logic [XLEN-1:0] f_base(input logic [3:0] op,
                                             input logic [XLEN-1:0] a,
                                             input logic [XLEN-1:0] b);
    logic [XLEN-1:0] res;
    logic [SHW-1:0]  sh;
    sh = b[SHW-1:0];
    case (op)
      4'b0000: res = a + b;
      4'b0110: res = a - b;
      4'b0001: res = a & b;
      4'b0010: res = a | b;
      4'b1011: res = a ^ b;
      4'b0100: res = a << sh;
      4'b1010: res = a >> sh;
      4'b1100: res = $signed(a) >>> sh;
      4'b1000: res = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      4'b0011: res = {{(XLEN-1){1'b0}}, (a < b)};
      default: res = '0;
    endcase
    return res;
  endfunction

  // Operand signedness: mulh signs both, mulhsu only a; div/rem sign both.
  logic            w_is_mul;
  logic            w_a_sgn, w_b_sgn, w_a_neg, w_b_neg;
  logic [XLEN-1:0] w_a_mag, w_b_mag;

  assign w_is_mul = (op_sel[4:2] == 3'b100);
  assign w_a_sgn  = w_is_mul ? (op_sel[1:0] == 2'b01 || op_sel[1:0] == 2'b10) : ~op_sel[0];
  assign w_b_sgn  = w_is_mul ? (op_sel[1:0] == 2'b01) : ~op_sel[0];
  assign w_a_neg  = w_a_sgn & operand_a[XLEN-1];
  assign w_b_neg  = w_b_sgn & operand_b[XLEN-1];
  assign w_a_mag  = w_a_neg ? -operand_a : operand_a;
  assign w_b_mag  = w_b_neg ? -operand_b : operand_b;

  logic [XLEN:0]     w_madd;
  logic [2*XLEN-1:0] w_mprod, w_mprod_s;

  assign w_madd    = {1'b0, r_hi} + {1'b0, (r_lo[0] ? r_opnd : {XLEN{1'b0}})};
  assign w_mprod   = {w_madd, r_lo[XLEN-1:1]};
  assign w_mprod_s = r_negq ? -w_mprod : w_mprod;

`ifdef ALU_MDU_DIV_EN
  logic            r_nega, w_nega_nxt;
  logic            w_is_div, w_ovf, w_dge;
  logic [XLEN:0]   w_dshift;
  logic [XLEN-1:0] w_ddiff, w_dhi, w_dlo, w_dq, w_dr;

  assign w_is_div = (op_sel[4:2] == 3'b101);
  assign w_ovf    = ~op_sel[0] && (operand_b == {XLEN{1'b1}}) &&
                    (operand_a == {1'b1, {(XLEN-1){1'b0}}});
  // Restoring step: partial remainder and quotient shift left together.
  assign w_dshift = {r_hi, r_lo[XLEN-1]};
  assign w_dge    = (w_dshift >= {1'b0, r_opnd});
  assign w_ddiff  = w_dshift[XLEN-1:0] - r_opnd;
  assign w_dhi    = w_dge ? w_ddiff : w_dshift[XLEN-1:0];
  assign w_dlo    = {r_lo[XLEN-2:0], w_dge};
  assign w_dq     = r_negq ? -w_dlo : w_dlo;
  assign w_dr     = r_nega ? -w_dhi : w_dhi;
`endif

  always_comb begin
    w_state_nxt  = r_state;
    w_result_nxt = r_result;
    w_hi_nxt     = r_hi;
    w_lo_nxt     = r_lo;
    w_opnd_nxt   = r_opnd;
    w_cnt_nxt    = r_cnt;
    w_fn_nxt     = r_fn;
    w_negq_nxt   = r_negq;
`ifdef ALU_MDU_DIV_EN
    w_nega_nxt   = r_nega;
`endif
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_fn_nxt   = op_sel[1:0];
          w_negq_nxt = w_a_neg ^ w_b_neg;
          w_hi_nxt   = '0;
          w_lo_nxt   = w_a_mag;
          w_opnd_nxt = w_b_mag;
          w_cnt_nxt  = SHW'(XLEN-1);
          if (w_is_mul) begin
            w_state_nxt = S_MUL;
          end
`ifdef ALU_MDU_DIV_EN
          else if (w_is_div) begin
            w_nega_nxt = w_a_neg;
            if (operand_b == '0) begin
              w_result_nxt = op_sel[1] ? operand_a : {XLEN{1'b1}};
              w_state_nxt  = S_DONE;
            end else if (w_ovf) begin
              w_result_nxt = op_sel[1] ? {XLEN{1'b0}} : operand_a;
              w_state_nxt  = S_DONE;
            end else begin
              w_state_nxt  = S_DIV;
            end
          end
`endif
          else begin
            w_result_nxt = op_sel[4] ? {XLEN{1'b0}} : f_base(op_sel[3:0], operand_a, operand_b);
            w_state_nxt  = S_DONE;
          end
        end
      end
      S_MUL: begin
        w_hi_nxt  = w_mprod[2*XLEN-1:XLEN];
        w_lo_nxt  = w_mprod[XLEN-1:0];
        w_cnt_nxt = r_cnt - SHW'(1);
        if (r_cnt == '0) begin
          w_result_nxt = (r_fn == 2'b00) ? w_mprod_s[XLEN-1:0] : w_mprod_s[2*XLEN-1:XLEN];
          w_state_nxt  = S_DONE;
        end
      end
`ifdef ALU_MDU_DIV_EN
      S_DIV: begin
        w_hi_nxt  = w_dhi;
        w_lo_nxt  = w_dlo;
        w_cnt_nxt = r_cnt - SHW'(1);
        if (r_cnt == '0) begin
          w_result_nxt = r_fn[1] ? w_dr : w_dq;
          w_state_nxt  = S_DONE;
        end
      end
`endif
      S_DONE: begin
        if (out_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_result <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_opnd   <= '0;
      r_cnt    <= '0;
      r_fn     <= '0;
      r_negq   <= 1'b0;
`ifdef ALU_MDU_DIV_EN
      r_nega   <= 1'b0;
`endif
    end else begin
      r_state  <= w_state_nxt;
      r_result <= w_result_nxt;
      r_hi     <= w_hi_nxt;
      r_lo     <= w_lo_nxt;
      r_opnd   <= w_opnd_nxt;
      r_cnt    <= w_cnt_nxt;
      r_fn     <= w_fn_nxt;
      r_negq   <= w_negq_nxt;
`ifdef ALU_MDU_DIV_EN
      r_nega   <= w_nega_nxt;
`endif
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state == S_MUL) || (r_state == S_DIV);
  assign result    = r_result;

endmodule

`default_nettype wire
